// File: rtl/sobel_edge.sv
// Sobel edge detector: 3x3 window fed by two line stores, |Gx|+|Gy| magnitude,
// 2-cycle pipeline from accepted pixel to oEdge/oBin/oDVAL, with border blanking.
module sobel_edge #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [11:0] iGauss,
    input  logic        iDVAL,
    input  logic        iFVAL,
    input  logic [11:0] iThresh,
    output logic [11:0] oEdge,
    output logic        oBin,
    output logic        oDVAL
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [11:0]           thresh;
    logic [11:0]           lineA [IMG_W];  // one line back
    logic [11:0]           lineB [IMG_W];  // two lines back
    logic [2:0][2:0][11:0] win, winNxt;
    logic                  accept, blank, blankS1;
    logic [2:1]            vldPipe;
    logic signed [15:0]    gx, gy;
    logic [13:0]           absGx, absGy;
    logic [14:0]           magSum;
    logic [11:0]           mag;

    function automatic logic signed [15:0] ext(input logic [11:0] p);
        return $signed({4'b0000, p});
    endfunction

    function automatic logic [13:0] absv(input logic signed [15:0] v);
        logic [15:0] a;
        a = v[15] ? 16'(-v) : 16'(v);
        return a[13:0];
    endfunction

    assign accept = iDVAL & iFVAL;
    assign blank  = (int'(col) < 2) || (int'(row) < 2);

    // Sobel runs on the window as it will look after this pixel shifts in,
    // so stage 1 captures the result on the accepting edge itself.
    always_comb begin
        winNxt = win;
        for (int r = 0; r < 3; r++) begin
            winNxt[r][0] = win[r][1];
            winNxt[r][1] = win[r][2];
        end
        winNxt[2][2] = iGauss;
        winNxt[1][2] = lineA[col];
        winNxt[0][2] = lineB[col];
    end

    always_comb begin
        gx = (ext(winNxt[0][2]) + (ext(winNxt[1][2]) <<< 1) + ext(winNxt[2][2]))
           - (ext(winNxt[0][0]) + (ext(winNxt[1][0]) <<< 1) + ext(winNxt[2][0]));
        gy = (ext(winNxt[2][0]) + (ext(winNxt[2][1]) <<< 1) + ext(winNxt[2][2]))
           - (ext(winNxt[0][0]) + (ext(winNxt[0][1]) <<< 1) + ext(winNxt[0][2]));
    end

    assign magSum = {1'b0, absGx} + {1'b0, absGy};
    assign mag    = magSum[14:3];
    assign oDVAL  = vldPipe[2];

    // Line stores carry no reset; stale contents are hidden by border blanking.
    always_ff @(posedge iCLK) begin
        if (accept) begin
            lineA[col] <= iGauss;
            lineB[col] <= lineA[col];
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col     <= '0;
            row     <= '0;
            thresh  <= '0;
            win     <= '0;
            vldPipe <= '0;
            blankS1 <= 1'b0;
            absGx   <= '0;
            absGy   <= '0;
            oEdge   <= '0;
            oBin    <= 1'b0;
        end else begin
            vldPipe <= {vldPipe[1], accept};
            if (!iFVAL) begin
                col    <= '0;
                row    <= '0;
                thresh <= iThresh;
            end else if (accept) begin
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    if (row != ROW_W'(IMG_H - 1))
                        row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (accept) begin
                win     <= winNxt;
                absGx   <= absv(gx);
                absGy   <= absv(gy);
                blankS1 <= blank;
            end
            if (vldPipe[1]) begin
                oEdge <= blankS1 ? 12'd0 : mag;
                oBin  <= !blankS1 && (mag >= thresh);
            end
        end
    end
endmodule

// File: doc/sobel_edge.md
SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 SHALL have parameter IMG_W, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, active lines per frame.
REQ-003 SHALL have port iCLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port iRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iGauss  input  12  smoothed grey pixel from the Gaussian stage, unsigned.
REQ-006 SHALL have port iDVAL  input  1  iGauss valid this cycle.
REQ-007 SHALL have port iFVAL  input  1  frame active; low between frames.
REQ-008 SHALL have port iThresh  input  12  edge threshold, unsigned.
REQ-009 SHALL have port oEdge  output  12  edge magnitude, unsigned.
REQ-010 SHALL have port oBin  output  1  binary edge flag.
REQ-011 SHALL have port oDVAL  output  1  oEdge/oBin valid.

Function
REQ-012 An input pixel SHALL be accepted only when iDVAL=1 and iFVAL=1; no other cycle changes window, line storage or counters.
REQ-013 Two IMG_W-deep line stores plus a 3x3 window register SHALL advance only on accepted pixels; no advance on idle cycles.
REQ-014 Window w[r][c]: r=2 current line, r=0 two lines back; c=2 newest pixel, c=0 oldest.
REQ-015 Gx = (w[0][2]+2w[1][2]+w[2][2]) - (w[0][0]+2w[1][0]+w[2][0]), signed, >=15 bits, no overflow.
REQ-016 Gy = (w[2][0]+2w[2][1]+w[2][2]) - (w[0][0]+2w[0][1]+w[0][2]), signed, >=15 bits, no overflow.
REQ-017 Stage 1 SHALL register |Gx| and |Gy| (14-bit unsigned each, max 16380).
REQ-018 Stage 2 SHALL register oEdge = (|Gx|+|Gy|) >> 3 (max 32760>>3 = 4095, no saturation needed) and oBin = (oEdge value >= thresh register).
REQ-019 oDVAL SHALL be the acceptance strobe (REQ-012) delayed exactly 2 clocks; latency from accepting pixel to its output = 2 cycles, throughput one pixel/clock.
REQ-020 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL give the position of the pixel being accepted; col increments per accepted pixel, wraps IMG_W-1 -> 0 and increments row.
REQ-021 row SHALL hold at IMG_H-1 on further wraps until iFVAL goes low (no wrap into a new frame).
REQ-022 While iFVAL=0, col and row SHALL be cleared to 0 and the thresh register SHALL load iThresh; thresh is constant while iFVAL=1.
REQ-023 Border blanking: if accepted pixel has col<2 or row<2, its output SHALL be oEdge=0, oBin=0, oDVAL still asserted.
REQ-024 Line store contents need not be reset or cleared between frames; REQ-023 masks stale data.
REQ-025 Outputs per frame SHALL equal accepted pixels per frame (IMG_W*IMG_H for a full frame).
REQ-026 iDVAL=1 with iFVAL=0 SHALL be ignored: no output, no state change except REQ-022.

Reset
REQ-027 On iRST=0, immediately: oEdge=0, oBin=0, oDVAL=0, col=0, row=0, stage-1/2 registers=0, window=0, thresh=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; pipelined pixels are discarded (no oDVAL after release until new accepted pixels propagate).
REQ-029 After release, first output SHALL come 2 clocks after the first accepted pixel.

Verification (IMG_W=8, IMG_H=4, iThresh=1000 loaded with iFVAL=0)
REQ-030 Reset: assert iRST with pipeline full -> oEdge=0, oBin=0, oDVAL=0 same cycle; counters 0.
REQ-031 Flat frame, all pixels 1000, iDVAL continuous -> 32 oDVAL pulses, every oEdge=0, oBin=0; first oDVAL 2 clocks after first pixel.
REQ-032 Vertical step, cols 0-3=0, cols 4-7=4095 -> rows 2-3, newest col 4 and 5: oEdge=2047, oBin=1; all other outputs oEdge=0, oBin=0; rows 0-1 all 0 (blanked).
REQ-033 Same step frame with 3 idle cycles inserted after every pixel -> identical oEdge/oBin sequence, 32 oDVAL pulses, each 2 clocks after its pixel.
REQ-034 Threshold edge: iThresh=2047 -> step pixels give oBin=1; iThresh=2048 -> oBin=0; change iThresh while iFVAL=1 -> no effect until next iFVAL low.
REQ-035 Reset pulsed during row 2, then a fresh full step frame -> outputs match REQ-032 exactly, no residue from the aborted frame.
